// File: rtl/serial_sub_8bit.sv
// serial_sub_8bit: bit-serial two's-complement subtractor, diff = a - b.
// One full-subtractor cell walks the operands LSB first, one bit per clock,
// behind a valid/ready operand port and a valid/ready result port.
module serial_sub_8bit #(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } st_t;

  st_t          st, st_nx;
  logic [W-1:0] sa, sb, res;
  logic [CW-1:0] cnt;
  logic         borrow;
  logic [W-1:0] diff_q;
  logic         bout_q;

  // full-subtractor cell on the current LSBs
  logic d, bnx, last;
  assign d    = sa[0] ^ sb[0] ^ borrow;
  assign bnx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign last = (cnt == CW'(W-1));

  assign in_ready   = (st == S_IDLE);
  assign out_valid  = (st == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nx;
  end

  // next-state: capture in IDLE, W serial steps in RUN, handshake out in DONE
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:  if (in_valid)  st_nx = S_RUN;
      S_RUN:   if (last)      st_nx = S_DONE;
      S_DONE:  if (out_ready) st_nx = S_IDLE;
      default:                st_nx = S_IDLE;
    endcase
  end

  // datapath: operand capture, serial shift, result latch on the final bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (in_valid) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          res    <= {d, res[W-1:1]};
          borrow <= bnx;
          cnt    <= cnt + CW'(1);
          // the last bit lands straight in the output register so diff is
          // stable for the whole DONE phase
          if (last) begin
            diff_q <= {d, res[W-1:1]};
            bout_q <= bnx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_8bit.sv
// tb_serial_sub_8bit: randomized self-checking bench for serial_sub_8bit,
// checked against plain modulo arithmetic.
module tb_serial_sub_8bit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         in_valid, in_ready;
  logic [W-1:0] diff;
  logic         borrow_out, out_valid, out_ready;

  int errors = 0;
  int checks = 0;

  serial_sub_8bit #(.W(W), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .diff(diff), .borrow_out(borrow_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    t = (int'(x) - int'(y) + 256) % 256;
    return W'(t);
  endfunction

  function automatic logic ref_bor(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // one operation; hold = cycles out_ready stays low once out_valid is up
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    int lat;
    logic [W-1:0] ed;
    logic eb;
    ed = ref_diff(x, y);
    eb = ref_bor(x, y);
    chk("pre_in_ready", in_ready, 1);
    a = x; b = y; in_valid = 1'b1; out_ready = (hold == 0);
    step();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) chk("busy_in_ready", in_ready, 0);
      a = W'($urandom); b = W'($urandom); in_valid = $urandom_range(0, 1);
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, W);
    chk("diff", diff, ed);
    chk("borrow", borrow_out, eb);
    for (int i = 0; i < hold; i++) begin
      in_valid = $urandom_range(0, 1);
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", diff, ed);
      chk("hold_borrow", borrow_out, eb);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("pulse_end", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] qa[$], qb[$], ed[$];
    logic         eb[$];
    logic [W-1:0] corners[4];
    int sent, got, low, cyc, first;
    corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h80; corners[3] = 8'h7F;

    rst_n = 1'b0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    rst_n = 1'b1;
    step();

    issue(8'h50, 8'h20, 0);
    issue(8'h00, 8'h01, 0);
    issue(8'hFF, 8'hFF, 0);
    issue(8'h20, 8'h50, 5);

    // reset in the middle of a run discards the operation
    a = 8'hA5; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (out_valid) seen++;
        step();
      end
      chk("midrst_no_output", seen, 0);
    end
    issue(8'hA5, 8'h3C, 0);

    // back-to-back stream, corners first then random pairs
    sent = 0; got = 0; low = 0; cyc = 0; first = 1;
    out_ready = 1'b1;
    while (got < 216 && cyc < 5000) begin
      if (out_valid) begin
        chk("b2b_diff", diff, ed.pop_front());
        chk("b2b_borrow", borrow_out, eb.pop_front());
        got++;
      end
      if (in_ready) begin
        if (!first) chk("issue_gap", low, W + 1);
        first = 0;
        low = 0;
        if (sent < 216) begin
          logic [W-1:0] x, y;
          if (sent < 16) begin x = corners[sent / 4]; y = corners[sent % 4]; end
          else begin x = W'($urandom); y = W'($urandom); end
          a = x; b = y;
          ed.push_back(ref_diff(x, y));
          eb.push_back(ref_bor(x, y));
          sent++;
        end
        in_valid = (sent <= 216);
      end else begin
        low++;
        a = W'($urandom); b = W'($urandom);
      end
      step();
      cyc++;
    end
    chk("b2b_count", got, 216);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
